program_loader: RTL and testbench

- Writer side of the MiniAlu instruction memory.
- Takes a byte stream over a valid/ready handshake, frames it, and assembles 28-bit instruction words.
- Writes those words sequentially into the dual-port instruction RAM that the core fetches from.
- Holds the core in reset until a complete, checksum-verified program has been written.

---
 rtl/program_loader_if.sv | 45 ++++
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-RAM write signals for the MiniAlu program loader.
// The loader is the slave: it consumes the stream and drives the RAM and core control.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSN_WIDTH = 28
) ();

  logic                  iStart;
  logic                  iByteValid;
  logic [7:0]            iByte;
  logic                  oByteReady;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [INSN_WIDTH-1:0] oWriteData;
  logic                  oCpuReset;
  logic                  oDone;
  logic                  oError;

  modport master (
    output iStart,
    output iByteValid,
    output iByte,
    input  oByteReady,
    input  oWriteEnable,
    input  oWriteAddress,
    input  oWriteData,
    input  oCpuReset,
    input  oDone,
    input  oError
  );

  modport slave (
    input  iStart,
    input  iByteValid,
    input  iByte,
    output oByteReady,
    output oWriteEnable,
    output oWriteAddress,
    output oWriteData,
    output oCpuReset,
    output oDone,
    output oError
  );

endinterface

// File: rtl/program_loader.sv
// Writer side of the MiniAlu instruction RAM: frames a length/payload/checksum byte
// stream into instruction words and holds the core in reset until a verified load.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSN_WIDTH = 28
) (
  input logic             Clock,
  input logic             Reset,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam longint unsigned MAX_WORDS = 64'(1) << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next;
  logic                  r_ready;
  logic                  r_we;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [INSN_WIDTH-1:0] r_wdata;
  logic [7:0]            r_len_hi;
  logic [7:0]            r_csum;
  logic [15:0]           r_words_left;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_word;

  logic                  w_accept;
  logic                  w_start;
  logic [15:0]           w_len;
  logic                  w_len_err;
  logic                  w_len_zero;
  logic                  w_word_done;
  logic                  w_last_word;
  logic                  w_csum_ok;

  // Keeps the low INSN_WIDTH bits of the big-endian 32-bit word.
  function automatic logic [INSN_WIDTH-1:0] f_pack_insn(input logic [23:0] upper,
                                                        input logic [7:0]  last);
    return INSN_WIDTH'({upper, last});
  endfunction

  assign w_accept    = bus.iByteValid & r_ready;
  assign w_start     = bus.iStart & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                     (r_state == S_ERROR));
  assign w_len       = {r_len_hi, bus.iByte};
  assign w_len_err   = 64'(w_len) > MAX_WORDS;
  assign w_len_zero  = (w_len == 16'd0);
  assign w_word_done = w_accept & (r_state == S_PAYLOAD) & (r_byte_cnt == 2'd3);
  assign w_last_word = (r_words_left == 16'd1);
  assign w_csum_ok   = (bus.iByte == r_csum);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (bus.iStart) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_err)       w_next = S_ERROR;
          else if (w_len_zero) w_next = S_CHECK;
          else                 w_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (w_word_done && w_last_word) w_next = S_CHECK;
      S_CHECK:   if (w_accept) w_next = w_csum_ok ? S_DONE : S_ERROR;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_len_hi     <= '0;
      r_csum       <= '0;
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
    end else begin
      // Ready is registered from the next state so it lines up with the state it serves.
      r_ready <= (w_next == S_LEN_HI) | (w_next == S_LEN_LO) |
                 (w_next == S_PAYLOAD) | (w_next == S_CHECK);
      r_we    <= w_word_done;
      if (r_we) r_addr <= r_addr + ADDR_WIDTH'(1);

      if (w_start) begin
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_cpu_reset <= 1'b1;
        r_addr      <= '0;
        r_byte_cnt  <= '0;
        r_csum      <= '0;
      end

      if (w_accept) begin
        unique case (r_state)
          S_LEN_HI: r_len_hi <= bus.iByte;
          S_LEN_LO: begin
            r_words_left <= w_len;
            if (w_len_err) r_error <= 1'b1;
          end
          S_PAYLOAD: begin
            r_csum     <= r_csum ^ bus.iByte;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= {r_word[15:0], bus.iByte};
            if (r_byte_cnt == 2'd3) begin
              r_wdata      <= f_pack_insn(r_word, bus.iByte);
              r_words_left <= r_words_left - 16'd1;
            end
          end
          S_CHECK: begin
            if (w_csum_ok) begin
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_error     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.oByteReady    = r_ready;
  assign bus.oWriteEnable  = r_we;
  assign bus.oWriteAddress = r_addr;
  assign bus.oWriteData    = r_wdata;
  assign bus.oCpuReset     = r_cpu_reset;
  assign bus.oDone         = r_done;
  assign bus.oError        = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum/length errors, stalls,
// address wrap and asynchronous reset in the middle of a load.
module tb_program_loader;

  localparam int AW = 8;
  localparam int IW = 28;

  logic clk;
  logic rst_n;

  program_loader_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int adj_cnt = 0;
  logic prev_we = 1'b0;
  logic [AW-1:0] wq_addr[$];
  logic [IW-1:0] wq_data[$];
  logic [7:0]    tx_q[$];

  always @(negedge clk) begin
    if (bus.oWriteEnable) begin
      wq_addr.push_back(bus.oWriteAddress);
      wq_data.push_back(bus.oWriteData);
      if (prev_we) adj_cnt <= adj_cnt + 1;
    end
    prev_we <= bus.oWriteEnable;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    int g;
    n = 0;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin @(posedge clk); #1; end
    bus.iByteValid = 1'b1;
    bus.iByte      = b;
    while (!bus.oByteReady && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("byte_ready_timeout", 32'(bus.oByteReady), 32'd1);
    @(posedge clk); #1;
    bus.iByteValid = 1'b0;
  endtask

  task automatic send_q(input bit gaps);
    foreach (tx_q[i]) send_byte(tx_q[i], gaps);
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    bus.iStart     = 1'b0;
    bus.iByteValid = 1'b0;
    bus.iByte      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.oByteReady),    32'd0);
    chk("rst_we",    32'(bus.oWriteEnable),  32'd0);
    chk("rst_addr",  32'(bus.oWriteAddress), 32'd0);
    chk("rst_data",  32'(bus.oWriteData),    32'd0);
    chk("rst_cpu",   32'(bus.oCpuReset),     32'd1);
    chk("rst_done",  32'(bus.oDone),         32'd0);
    chk("rst_err",   32'(bus.oError),        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(bus.oByteReady), 32'd0);

    // Two-word load with a good checksum (0x8C).
    clear_writes();
    pulse_start();
    chk("t1_ready", 32'(bus.oByteReady), 32'd1);
    tx_q = '{8'h00, 8'h02, 8'h0A, 8'h12, 8'h34, 8'h56, 8'hF1, 8'h00, 8'h00, 8'h07};
    send_q(1'b0);
    chk("t1_cpu_before_csum", 32'(bus.oCpuReset), 32'd1);
    send_byte(8'h8C, 1'b0);
    chk("t1_nwr",   32'(wq_addr.size()), 32'd2);
    chk("t1_a0",    32'(wq_addr[0]), 32'h00);
    chk("t1_d0",    32'(wq_data[0]), 32'h0A123456);
    chk("t1_a1",    32'(wq_addr[1]), 32'h01);
    chk("t1_d1",    32'(wq_data[1]), 32'h01000007);
    chk("t1_done",  32'(bus.oDone),      32'd1);
    chk("t1_err",   32'(bus.oError),     32'd0);
    chk("t1_cpu",   32'(bus.oCpuReset),  32'd0);
    chk("t1_ready_off", 32'(bus.oByteReady), 32'd0);

    // Same frame, checksum off by one bit; restart from DONE.
    clear_writes();
    pulse_start();
    chk("t2_done_clr", 32'(bus.oDone),     32'd0);
    chk("t2_cpu_set",  32'(bus.oCpuReset), 32'd1);
    tx_q = '{8'h00, 8'h02, 8'h0A, 8'h12, 8'h34, 8'h56, 8'hF1, 8'h00, 8'h00, 8'h07, 8'h8D};
    send_q(1'b0);
    chk("t2_nwr",  32'(wq_addr.size()), 32'd2);
    chk("t2_d0",   32'(wq_data[0]), 32'h0A123456);
    chk("t2_d1",   32'(wq_data[1]), 32'h01000007);
    chk("t2_err",  32'(bus.oError),    32'd1);
    chk("t2_done", 32'(bus.oDone),     32'd0);
    chk("t2_cpu",  32'(bus.oCpuReset), 32'd1);

    // Empty program: good and bad checksum.
    clear_writes();
    pulse_start();
    chk("t3_err_clr", 32'(bus.oError), 32'd0);
    tx_q = '{8'h00, 8'h00, 8'h00};
    send_q(1'b0);
    chk("t3a_nwr",  32'(wq_addr.size()), 32'd0);
    chk("t3a_done", 32'(bus.oDone),      32'd1);
    chk("t3a_cpu",  32'(bus.oCpuReset),  32'd0);
    pulse_start();
    tx_q = '{8'h00, 8'h00, 8'h5A};
    send_q(1'b0);
    chk("t3b_err",  32'(bus.oError), 32'd1);
    chk("t3b_done", 32'(bus.oDone),  32'd0);

    // Oversized length (257) errors right after the low length byte.
    clear_writes();
    pulse_start();
    tx_q = '{8'h01, 8'h01};
    send_q(1'b0);
    chk("t4_err",   32'(bus.oError),     32'd1);
    chk("t4_ready", 32'(bus.oByteReady), 32'd0);
    chk("t4_done",  32'(bus.oDone),      32'd0);
    bus.iByteValid = 1'b1;
    bus.iByte      = 8'h33;
    repeat (3) begin @(posedge clk); #1; end
    bus.iByteValid = 1'b0;
    chk("t4_ignored_err",   32'(bus.oError),     32'd1);
    chk("t4_ignored_ready", 32'(bus.oByteReady), 32'd0);
    chk("t4_nwr",  32'(wq_addr.size()), 32'd0);

    // Three words with random valid gaps; checksum 0xF0.
    clear_writes();
    pulse_start();
    tx_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
             8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hF0};
    send_q(1'b1);
    chk("t5_nwr",  32'(wq_addr.size()), 32'd3);
    chk("t5_a2",   32'(wq_addr[2]), 32'h02);
    chk("t5_d0",   32'(wq_data[0]), 32'h02345678);
    chk("t5_d1",   32'(wq_data[1]), 32'h0ABCDEF0);
    chk("t5_d2",   32'(wq_data[2]), 32'h0FFFFFFF);
    chk("t5_done", 32'(bus.oDone), 32'd1);

    // Full RAM (256 words): last write at 0xFF, address then wraps to 0.
    clear_writes();
    pulse_start();
    tx_q = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'(i));
    end
    tx_q.push_back(8'h00);
    send_q(1'b0);
    chk("t6_nwr",   32'(wq_addr.size()), 32'd256);
    chk("t6_a_last", 32'(wq_addr[255]), 32'hFF);
    chk("t6_d_last", 32'(wq_data[255]), 32'hFF);
    chk("t6_d_mid",  32'(wq_data[100]), 32'd100);
    chk("t6_wrap",  32'(bus.oWriteAddress), 32'd0);
    chk("t6_done",  32'(bus.oDone), 32'd1);
    chk("adjacent_we", 32'(adj_cnt), 32'd0);

    // Asynchronous reset in the middle of word 2.
    clear_writes();
    pulse_start();
    tx_q = '{8'h00, 8'h02, 8'h0A, 8'h12, 8'h34, 8'h56, 8'hF1, 8'h00};
    send_q(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_ready", 32'(bus.oByteReady),    32'd0);
    chk("t7_we",    32'(bus.oWriteEnable),  32'd0);
    chk("t7_addr",  32'(bus.oWriteAddress), 32'd0);
    chk("t7_data",  32'(bus.oWriteData),    32'd0);
    chk("t7_cpu",   32'(bus.oCpuReset),     32'd1);
    chk("t7_done",  32'(bus.oDone),         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_writes();
    pulse_start();
    tx_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_q(1'b0);
    chk("t7_nwr",  32'(wq_addr.size()), 32'd1);
    chk("t7_a0",   32'(wq_addr[0]), 32'h00);
    chk("t7_d0",   32'(wq_data[0]), 32'h01223344);
    chk("t7_done2", 32'(bus.oDone),     32'd1);
    chk("t7_cpu2",  32'(bus.oCpuReset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
